uart_tx_scheduler: RTL and testbench

//  Queues bytes written by the CPU to the UART TX data register (0x40000018) and sequences them,
//  one at a time, into the UART transmitter using its idle status and a one-cycle send strobe.

---
 rtl/uart_tx_scheduler_pkg.sv | 16 +
 rtl/uart_tx_scheduler_fifo.sv | 60 ++++++
 rtl/uart_tx_scheduler.sv | 152 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants for the UART TX scheduler: peripheral addresses and the
// 3-bit encodings of the transmit sequencer states.
package uart_tx_scheduler_pkg;

  localparam logic [31:0] TX_DATA_ADDR   = 32'h4000_0018;
  localparam logic [31:0] UART_CTRL_ADDR = 32'h4000_0020;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_scheduler_fifo.sv
// Synchronous FIFO for queued TX bytes. Flush clears pointers and count and
// overrides any push in the same cycle. A push into a full FIFO lands only
// when a pop happens in the same cycle.
module uart_tx_scheduler_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    level,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             wr;
  logic             rd;

  assign full  = (count == CW'(DEPTH));
  assign level = count;
  assign dout  = mem[head];
  assign rd    = pop && (count != '0) && !flush;
  assign wr    = push && !flush && (!full || rd);

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[tail] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr) tail <= tail + AW'(1);
      if (rd) head <= head + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues CPU TX bytes and hands them one at a time to the UART core.
// Optional drain-complete interrupt is built when UART_TX_IRQ_EN is defined.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          flush,
  input  logic          clr_err,
  input  logic          tx_status,
  output logic [7:0]    tx_data,
  output logic          tx_send,
  output logic [CW-1:0] level,
  output logic          full,
  output logic          busy,
  output logic          ovf,
  output logic          tmo,
  output logic          irq
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  state_t        state;
  state_t        state_next;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_level;
  logic          fifo_full;
  logic          pop;
  logic          ovf_set;
  logic          tmo_set;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    tx_data_q;
  logic          tx_send_q;
  logic          ovf_q;
  logic          tmo_q;

  uart_tx_scheduler_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_data),
    .dout  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full)
  );

  // Handshake: a byte is offered only while tx_status=1 (UART idle); tx_send
  // is a one-cycle strobe with tx_data already stable; the UART acknowledges
  // by dropping tx_status and signals completion by raising it again.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tmo_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((fifo_level != '0) && tx_status) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        // A flush in the cycle we left IDLE can empty the FIFO under us.
        if (fifo_level != '0) begin
          pop        = 1'b1;
          state_next = ST_SEND;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SEND: state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!tx_status) begin
          state_next = ST_WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_set    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_status) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ovf_set = push && !flush && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      tmo_cnt   <= '0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state     <= state_next;
      // Registered strobe: asserted exactly for the SEND cycle, glitch-free.
      tx_send_q <= pop;
      if (pop) tx_data_q <= fifo_head;
      if (state == ST_SEND) begin
        tmo_cnt <= '0;
      end else if (state == ST_WAIT_BUSY) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (ovf_set)      ovf_q <= 1'b1;
      else if (clr_err) ovf_q <= 1'b0;
      if (tmo_set)      tmo_q <= 1'b1;
      else if (clr_err) tmo_q <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_q;
  logic sent_any;
  logic drain_done;

  assign drain_done = ((state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE)) &&
                      (state_next == ST_IDLE) && (fifo_level == '0) && sent_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q    <= 1'b0;
      sent_any <= 1'b0;
    end else begin
      if (state == ST_SEND) sent_any <= 1'b1;
      else if (drain_done)  sent_any <= 1'b0;
      if (push || flush || clr_err) irq_q <= 1'b0;
      else if (drain_done)          irq_q <= 1'b1;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;
  assign level   = fifo_level;
  assign full    = fifo_full;
  assign busy    = (state != ST_IDLE) || (fifo_level != '0);
  assign ovf     = ovf_q;
  assign tmo     = tmo_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: table-driven fill/overflow vectors
// plus directed sequences for latency, timeout, flush, irq and async reset.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic       tx_status = 1'b1;
  logic [7:0] tx_data;
  logic       tx_send;
  logic [3:0] level;
  logic       full;
  logic       busy;
  logic       ovf;
  logic       tmo;
  logic       irq;

`ifdef UART_TX_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  uart_tx_scheduler #(.DEPTH(8), .BUSY_TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .flush     (flush),
    .clr_err   (clr_err),
    .tx_status (tx_status),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .level     (level),
    .full      (full),
    .busy      (busy),
    .ovf       (ovf),
    .tmo       (tmo),
    .irq       (irq)
  );

  // clock / cycle counter / strobe monitor
  always #5 clk = ~clk;

  int   cyc = 0;
  int   send_count = 0;
  logic irq_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_send === 1'b1) send_count <= send_count + 1;
    if (irq === 1'b1) irq_seen <= 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic       clr;
    logic       txs;
    logic [3:0] lvl;
    logic       full;
    logic       ovf;
    logic       q;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic p, input logic [7:0] d, input logic c,
                              input logic t, input logic [3:0] l, input logic f,
                              input logic o, input logic q);
    vec_t v;
    v.push = p; v.data = d; v.clr = c; v.txs = t;
    v.lvl = l; v.full = f; v.ovf = o; v.q = q;
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic q);
    push = 1'b1;
    push_data = d;
    if (q) exp_q.push_back(d);
    tick();
    push = 1'b0;
  endtask

  task automatic wait_send(output int send_cyc, output logic [7:0] exp_b);
    int n = 0;
    exp_b = 8'h00;
    while (tx_send !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    send_cyc = cyc;
    check("send_seen", 32'(tx_send), 32'd1);
    if (tx_send === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_send: got byte 0x%0h expected no strobe", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(exp_b));
      end
    end
  endtask

  // UART model: acknowledge the strobe, stay busy, then go idle again.
  task automatic serve(input int busy_cycles, output int send_cyc);
    logic [7:0] e;
    wait_send(send_cyc, e);
    if (tx_send === 1'b1) begin
      tx_status = 1'b0;
      tick();
      check("send_pulse", 32'(tx_send), 32'd0);
      check("tx_data_hold", 32'(tx_data), 32'(e));
      repeat (busy_cycles - 1) tick();
      tx_status = 1'b1;
    end
  endtask

  initial begin
    int         c;
    int         n0;
    logic [7:0] e;

    // reset state
    reset = 1'b0;
    tick();
    tick();
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b1;
    tick();

    // single byte latency
    n0 = cyc;
    push_byte(8'h55, 1'b1);
    check("t1_level_after_push", 32'(level), 32'd1);
    serve(3, c);
    check("t1_latency", 32'(c - n0), 32'd3);
    tick();
    tick();
    check("t1_level_drained", 32'(level), 32'd0);
    check("t1_busy_drained", 32'(busy), 32'd0);

    // fill, overflow, clr_err precedence, push during LOAD when full
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0, 4'(i + 1), (i == 7), 1'b0, 1'b1);
    vecs[8]  = mk(1'b1, 8'hA9, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1, 1'b0);
    vecs[9]  = mk(1'b1, 8'hAA, 1'b1, 1'b0, 4'd8, 1'b1, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 8'hB0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) begin
      push      = vecs[i].push;
      push_data = vecs[i].data;
      clr_err   = vecs[i].clr;
      tx_status = vecs[i].txs;
      if (vecs[i].push && vecs[i].q) exp_q.push_back(vecs[i].data);
      tick();
      check($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].full));
      check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
    end
    push = 1'b0;
    clr_err = 1'b0;
    for (int i = 0; i < 9; i++) serve(3, c);
    tick();
    tick();
    check("t2_level_drained", 32'(level), 32'd0);
    check("t2_full_drained", 32'(full), 32'd0);
    check("t2_busy_drained", 32'(busy), 32'd0);
    check("t2_send_count", 32'(send_count), 32'd10);

    // busy timeout
    tx_status = 1'b1;
    push_byte(8'hC1, 1'b1);
    push_byte(8'hC2, 1'b1);
    wait_send(c, e);
    repeat (16) tick();
    check("t4_tmo_not_early", 32'(tmo), 32'd0);
    tick();
    check("t4_tmo_set", 32'(tmo), 32'd1);
    check("t4_level_next", 32'(level), 32'd1);
    serve(3, c);
    check("t4_tmo_sticky", 32'(tmo), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t4_tmo_cleared", 32'(tmo), 32'd0);
    tick();

    // flush during WAIT_DONE of the first byte
    tx_status = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'hD1 + i), (i == 0));
    check("t5_level4", 32'(level), 32'd4);
    tx_status = 1'b1;
    wait_send(c, e);
    tx_status = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    push = 1'b1;
    push_data = 8'hEE;
    tick();
    flush = 1'b0;
    push = 1'b0;
    check("t5_level_flushed", 32'(level), 32'd0);
    check("t5_ovf_flush", 32'(ovf), 32'd0);
    check("t5_busy_wait_done", 32'(busy), 32'd1);
    tx_status = 1'b1;
    tick();
    check("t5_busy_fall", 32'(busy), 32'd0);
    repeat (6) tick();
    check("t5_send_count", 32'(send_count), 32'd13);

    // flush with push into a full FIFO
    tx_status = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i), 1'b0);
    check("t5b_full", 32'(full), 32'd1);
    flush = 1'b1;
    push = 1'b1;
    push_data = 8'h99;
    tick();
    flush = 1'b0;
    push = 1'b0;
    check("t5b_level", 32'(level), 32'd0);
    check("t5b_full_clear", 32'(full), 32'd0);
    check("t5b_ovf", 32'(ovf), 32'd0);

    // drain-complete interrupt
    tx_status = 1'b1;
    check("t6_irq_start", 32'(irq), 32'd0);
    push_byte(8'hE1, 1'b1);
    push_byte(8'hE2, 1'b1);
    serve(3, c);
    check("t6_irq_mid", 32'(irq), 32'd0);
    serve(3, c);
    tick();
    check("t6_irq_drained", 32'(irq), 32'(IRQ_EXP));
    tx_status = 1'b0;
    push_byte(8'hF1, 1'b0);
    check("t6_irq_push_clear", 32'(irq), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifndef UART_TX_IRQ_EN
    check("t6_irq_never", 32'(irq_seen), 32'd0);
`endif
    check("t6_send_count", 32'(send_count), 32'd15);

    // async reset mid-transfer
    tx_status = 1'b1;
    push_byte(8'h77, 1'b1);
    push_byte(8'h78, 1'b0);
    wait_send(c, e);
    #1;
    reset = 1'b0;
    #1;
    check("t7_rst_tx_send", 32'(tx_send), 32'd0);
    check("t7_rst_tx_data", 32'(tx_data), 32'd0);
    check("t7_rst_level", 32'(level), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("t7_post_tx_send", 32'(tx_send), 32'd0);
    check("t7_post_busy", 32'(busy), 32'd0);
    check("t7_exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
